sdiv_frontend: RTL and testbench

Signed/unsigned division front-end that sits directly upstream of the team's iterative unsigned divider (`N = M = W`). It converts a valid/ready request stream into the divider's start/done protocol. It takes operand magnitudes, short-circuits divide-by-zero, restores result signs, and holds the result until the consumer accepts it. One request is in flight at a time.

---
 rtl/sdiv_frontend.sv | 137 +++++++++++++
 tb/tb_sdiv_frontend.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_frontend.sv
// rtl/sdiv_frontend.sv - signed/unsigned division front-end for the iterative unsigned divider
// Converts a valid/ready request into start/done, takes magnitudes, restores signs and holds the result.
module sdiv_frontend #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_dividend,
  input  logic [W-1:0] i_in_divisor,
  input  logic         i_in_signed,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_quotient,
  output logic [W-1:0] o_out_remainder,
  output logic         o_out_dbz,
  output logic         o_div_start,
  output logic [W-1:0] o_div_dividend,
  output logic [W-1:0] o_div_divisor,
  input  logic [W-1:0] i_div_quotient,
  input  logic [W-1:0] i_div_remainder,
  input  logic         i_div_done
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [W-1:0] r_mag_a;
  logic [W-1:0] r_mag_b;
  logic [W-1:0] r_raw_a;
  logic [W-1:0] r_q;
  logic [W-1:0] r_r;
  logic         r_neg_q;
  logic         r_neg_r;
  logic         r_dbz;
  logic         r_out_dbz;

  logic         w_accept;
  logic         w_load_div;
  logic         w_load_dbz;
  logic         w_sign_a;
  logic         w_sign_b;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;

  assign w_sign_a = i_in_signed & i_in_dividend[W-1];
  assign w_sign_b = i_in_signed & i_in_divisor[W-1];
  assign w_abs_a  = w_sign_a ? -i_in_dividend : i_in_dividend;
  assign w_abs_b  = w_sign_b ? -i_in_divisor  : i_in_divisor;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // div_done is only looked at in S_WAIT, so a level left high from the previous run is harmless
  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_div_start = 1'b0;
    w_accept    = 1'b0;
    w_load_div  = 1'b0;
    w_load_dbz  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept = 1'b1;
          w_next   = S_START;
        end
      end
      S_START: begin
        if (r_dbz) begin
          w_load_dbz = 1'b1;
          w_next     = S_OUT;
        end else begin
          o_div_start = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_div_done) begin
          w_load_div = 1'b1;
          w_next     = S_OUT;
        end
      end
      S_OUT: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_raw_a   <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_q       <= '0;
      r_r       <= '0;
      r_out_dbz <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mag_a <= w_abs_a;
        r_mag_b <= w_abs_b;
        r_raw_a <= i_in_dividend;
        r_neg_q <= w_sign_a ^ w_sign_b;
        r_neg_r <= w_sign_a;
        r_dbz   <= (i_in_divisor == '0);
      end
      if (w_load_dbz) begin
        r_q       <= '1;
        r_r       <= r_raw_a;
        r_out_dbz <= 1'b1;
      end
      if (w_load_div) begin
        r_q       <= r_neg_q ? -i_div_quotient  : i_div_quotient;
        r_r       <= r_neg_r ? -i_div_remainder : i_div_remainder;
        r_out_dbz <= 1'b0;
      end
    end
  end

  assign o_out_quotient  = r_q;
  assign o_out_remainder = r_r;
  assign o_out_dbz       = r_out_dbz;
  assign o_div_dividend  = r_mag_a;
  assign o_div_divisor   = r_mag_b;

endmodule

// File: tb/tb_sdiv_frontend.sv
// tb/tb_sdiv_frontend.sv - directed-vector bench for sdiv_frontend with a behavioural divider
module tb_sdiv_frontend;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         in_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_dbz;
  logic         div_start;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         div_done;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  sdiv_frontend #(.W(W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_dividend(in_dividend), .i_in_divisor(in_divisor), .i_in_signed(in_signed),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_quotient(out_quotient), .o_out_remainder(out_remainder), .o_out_dbz(out_dbz),
    .o_div_start(div_start), .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
    .i_div_quotient(div_quotient), .i_div_remainder(div_remainder), .i_div_done(div_done)
  );

  // Divider model: samples start, raises done W edges later and holds it until the next start
  logic         m_busy;
  int           m_cnt;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 0; div_done <= 1'b0;
      div_quotient <= '0; div_remainder <= '0; m_a <= '0; m_b <= '0;
    end else if (div_start) begin
      m_busy <= 1'b1; m_cnt <= 1; div_done <= 1'b0;
      m_a <= div_dividend; m_b <= div_divisor;
    end else if (m_busy) begin
      if (m_cnt == W) begin
        m_busy <= 1'b0; div_done <= 1'b1;
        div_quotient <= m_a / m_b; div_remainder <= m_a % m_b;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = s;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge; latency counts the accept edge as edge 1
  task automatic finish_req(input string tag, input logic [W-1:0] ma, input logic [W-1:0] mb,
                            input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                            input int elat, input int s0);
    int lat = 1;
    @(negedge clk);
    chk({tag, "_in_ready_low"}, in_ready, 1'b0);
    chk({tag, "_mag_a"}, div_dividend, ma);
    chk({tag, "_mag_b"}, div_divisor, mb);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_quot"}, out_quotient, eq);
    chk({tag, "_rem"}, out_remainder, er);
    chk({tag, "_dbz"}, out_dbz, ed);
    chk({tag, "_starts"}, start_cnt - s0, ed ? 0 : 1);
  endtask

  task automatic pop(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_after_pop"}, out_valid, 1'b0);
    chk({tag, "_ready_after_pop"}, in_ready, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed,
                        input int elat);
    int s0;
    s0 = start_cnt;
    send(a, b, s);
    finish_req(tag, ma, mb, eq, er, ed, elat, s0);
    pop(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_quot"}, out_quotient, 0);
    chk({tag, "_rem"}, out_remainder, 0);
    chk({tag, "_dbz"}, out_dbz, 1'b0);
    chk({tag, "_start"}, div_start, 1'b0);
    chk({tag, "_div_a"}, div_dividend, 0);
    chk({tag, "_div_b"}, div_divisor, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int seen;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_req("u200_7",   8'd200, 8'd7,  1'b0, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, W + 3);
    do_req("s_m7_2",   8'hF9,  8'h02, 1'b1, 8'h07, 8'h02, 8'hFD, 8'hFF, 1'b0, W + 3);
    do_req("s_7_m2",   8'h07,  8'hFE, 1'b1, 8'h07, 8'h02, 8'hFD, 8'h01, 1'b0, W + 3);
    do_req("s_ovf",    8'h80,  8'hFF, 1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, W + 3);
    do_req("u_80_ff",  8'h80,  8'hFF, 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, W + 3);
    do_req("dbz_s",    8'h37,  8'h00, 1'b1, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 2);
    do_req("dbz_u",    8'h37,  8'h00, 1'b0, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 2);

    // Backpressure, then a back-to-back request while the divider still holds done high
    s0 = start_cnt;
    send(8'd200, 8'd7, 1'b0);
    finish_req("bp", 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, W + 3, s0);
    in_valid = 1'b1; in_dividend = 8'h56; in_divisor = 8'h05; in_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_quot", out_quotient, 8'h1C);
      chk("bp_rem", out_remainder, 8'h04);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_start", div_start, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid_after_pop", out_valid, 1'b0);
    chk("bp_ready_after_pop", in_ready, 1'b1);
    s0 = start_cnt;
    @(posedge clk);
    #1 in_valid = 1'b0;
    finish_req("b2b", 8'h56, 8'h05, 8'h11, 8'h01, 1'b0, W + 3, s0);
    pop("b2b");

    // Reset while the divider is working
    send(8'h40, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("midrst_no_valid", seen, 0);
    do_req("post_rst", 8'd100, 8'd9, 1'b0, 8'h64, 8'h09, 8'h0B, 8'h01, 1'b0, W + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
